// File: rtl/sl_transmitter.sv
// sl_transmitter: register-programmed SL0/SL1 serial transmitter.
// Sends length data bits MSB-first, an odd-parity bit, then a stop symbol.
module sl_transmitter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        SL0,
    output logic        SL1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_STOP_LOW,
        S_STOP_HIGH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [32:0] shift_q, shift_d;
    logic [5:0]  bits_q, bits_d;
    logic [6:0]  tmr_q, tmr_d;
    logic [5:0]  len_q, len_d;
    logic [2:0]  mode_q, mode_d;
    logic        done_q, done_d;
    logic        sl0_q, sl0_d;
    logic        sl1_q, sl1_d;

    logic        busy;
    logic        tmr_done;
    logic [6:0]  half_m1;
    logic [5:0]  pad;
    logic [31:0] mask;
    logic        par;
    logic [32:0] frame;
    logic [5:0]  len_w;
    logic [2:0]  mode_w;

    assign busy     = (state_q != S_IDLE);
    assign tmr_done = (tmr_q == 7'd0);
    assign half_m1  = 7'((8'd4 << mode_q) - 8'd1);

    // Frame is {data, parity} left-aligned so bit 32 is always next out.
    assign pad   = 6'd32 - len_q;
    assign mask  = 32'hFFFF_FFFF >> pad;
    assign par   = ~^(d_in & mask);
    assign frame = {d_in, par} << pad;

    always_comb begin
        len_w = d_in[5:0];
        if (d_in[5:0] < 6'd8) begin
            len_w = 6'd8;
        end else if (d_in[5:0] > 6'd32) begin
            len_w = 6'd32;
        end
        mode_w = (d_in[9:7] > 3'd5) ? 3'd5 : d_in[9:7];
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        tmr_d   = tmr_q;
        len_d   = len_q;
        mode_d  = mode_q;
        done_d  = done_q;
        sl0_d   = 1'b1;
        sl1_d   = 1'b1;

        // len/mode are frozen while busy, so they hold for the whole frame.
        if (wr_en && addr && !busy) begin
            len_d  = len_w;
            mode_d = mode_w;
        end
        if (wr_en && addr && !d_in[24]) begin
            done_d = 1'b0;
        end
        if (busy) begin
            tmr_d = tmr_done ? half_m1 : tmr_q - 7'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (wr_en && !addr) begin
                    data_d  = d_in;
                    shift_d = frame;
                    bits_d  = len_q + 6'd1;
                    tmr_d   = half_m1;
                    state_d = S_BIT_LOW;
                end
            end
            S_BIT_LOW: begin
                if (tmr_done) state_d = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (tmr_done) begin
                    if (bits_q == 6'd1) begin
                        state_d = S_STOP_LOW;
                    end else begin
                        bits_d  = bits_q - 6'd1;
                        shift_d = shift_q << 1;
                        state_d = S_BIT_LOW;
                    end
                end
            end
            S_STOP_LOW: begin
                if (tmr_done) state_d = S_STOP_HIGH;
            end
            S_STOP_HIGH: begin
                if (tmr_done) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_BIT_LOW: begin
                sl0_d = shift_d[32];
                sl1_d = ~shift_d[32];
            end
            S_STOP_LOW: begin
                sl0_d = 1'b0;
                sl1_d = 1'b0;
            end
            default: begin
                sl0_d = 1'b1;
                sl1_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= 32'd0;
            shift_q <= 33'd0;
            bits_q  <= 6'd0;
            tmr_q   <= 7'd0;
            len_q   <= 6'd8;
            mode_q  <= 3'd0;
            done_q  <= 1'b0;
            sl0_q   <= 1'b1;
            sl1_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            tmr_q   <= tmr_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            sl0_q   <= sl0_d;
            sl1_q   <= sl1_d;
        end
    end

    assign SL0 = sl0_q;
    assign SL1 = sl1_q;

    always_comb begin
        if (addr) begin
            d_out = {7'd0, done_q, 7'd0, busy, 6'd0, mode_q, 1'b0, len_q};
        end else begin
            d_out = data_q;
        end
    end

endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: random frames checked against a waveform model
// and an ideal SL receiver that decodes the lines back into bits.
module tb_sl_transmitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        addr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        SL0;
    logic        SL1;

    sl_transmitter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .addr (addr),
        .d_in (d_in),
        .d_out(d_out),
        .SL0  (SL0),
        .SL1  (SL1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_len = 8;
    int exp_mode = 0;
    logic exp_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input int v);
        if (v < 8) return 8;
        if (v > 32) return 32;
        return v;
    endfunction

    function automatic int clamp_mode(input int v);
        return (v > 5) ? 5 : v;
    endfunction

    function automatic logic [31:0] low_mask(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    // Only used while idle; [24]=1 so done is left alone.
    task automatic ctrl_write(input int len, input int mode);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = 1'b1;
        d_in  = 32'h0100_0000 | ((mode & 7) << 7) | (len & 63);
        @(negedge clk);
        wr_en = 1'b0;
        exp_len  = clamp_len(len & 63);
        exp_mode = clamp_mode(mode & 7);
        #1;
        chk("cfg_len", {26'd0, d_out[5:0]}, exp_len);
        chk("cfg_mode", {29'd0, d_out[9:7]}, exp_mode);
        chk("cfg_done", {31'd0, d_out[24]}, {31'd0, exp_done});
    endtask

    // act: 0 none, 1 CTRL write (clear done, len 20, mode 3), 2 DATA write
    task automatic send_frame(input logic [31:0] data, input int act,
                              input int act_at);
        int t, f, bad, k, j, w, nbits, ones, wbad, stops;
        logic [1:0] expw[$];
        logic [1:0] obs[$];
        logic       rx[$];
        logic [31:0] word, dm;
        int         np;

        t  = 4 << exp_mode;
        f  = (exp_len + 2) * 2 * t;
        dm = data & low_mask(exp_len);
        np = $countones(dm);

        for (int b = exp_len; b >= 0; b--) begin
            logic bit_v;
            bit_v = (b == 0) ? ((np % 2) == 0) : dm[b-1];
            for (int c = 0; c < t; c++) expw.push_back(bit_v ? 2'b10 : 2'b01);
            for (int c = 0; c < t; c++) expw.push_back(2'b11);
        end
        for (int c = 0; c < t; c++) expw.push_back(2'b00);
        for (int c = 0; c < t; c++) expw.push_back(2'b11);

        @(negedge clk);
        addr = 1'b1;
        #1;
        chk("busy_pre", {31'd0, d_out[16]}, 32'd0);
        wr_en = 1'b1;
        addr  = 1'b0;
        d_in  = data;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = 1'b1;
        #1;
        chk("busy_first", {31'd0, d_out[16]}, 32'd1);

        for (int i = 0; i < f; i++) begin
            if (i > 0) @(negedge clk);
            obs.push_back({SL0, SL1});
            if (act != 0 && i == act_at + 1) begin
                wr_en = 1'b0;
                addr  = 1'b1;
                #1;
                if (act == 1) begin
                    exp_done = 1'b0;
                    chk("clr_done", {31'd0, d_out[24]}, 32'd0);
                    chk("busy_len", {26'd0, d_out[5:0]}, exp_len);
                    chk("busy_mode", {29'd0, d_out[9:7]}, exp_mode);
                end
            end
            if (act != 0 && i == act_at) begin
                wr_en = 1'b1;
                if (act == 1) begin
                    addr = 1'b1;
                    d_in = (32'd3 << 7) | 32'd20;
                end else begin
                    addr = 1'b0;
                    d_in = ~data;
                end
            end
            if (i == f - 1) begin
                chk("busy_last", {31'd0, d_out[16]}, 32'd1);
            end
        end

        @(negedge clk);
        #1;
        exp_done = 1'b1;
        chk("idle_lines", {30'd0, SL0, SL1}, 32'd3);
        chk("busy_end", {31'd0, d_out[16]}, 32'd0);
        chk("done_end", {31'd0, d_out[24]}, 32'd1);
        addr = 1'b0;
        #1;
        chk("data_rb", d_out, data);
        addr = 1'b1;

        bad = -1;
        for (int i = 0; i < f; i++) begin
            if (obs[i] !== expw[i] && bad < 0) bad = i;
        end
        chk("wave", bad, -1);

        k = 0;
        wbad = 0;
        stops = 0;
        while (k < obs.size()) begin
            if (obs[k] == 2'b11) begin
                k++;
            end else begin
                j = k;
                while (j < obs.size() && obs[j] == obs[k]) j++;
                w = j - k;
                if (w != t) wbad++;
                if (obs[k] == 2'b00) stops++;
                else rx.push_back(obs[k] == 2'b10);
                k = j;
            end
        end
        nbits = rx.size();
        word = 32'd0;
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i < exp_len) word = {word[30:0], rx[i]};
            ones += rx[i];
        end
        chk("rx_count", nbits - 1, exp_len);
        chk("rx_word", word, dm);
        chk("rx_parity", ones % 2, 1);
        chk("rx_width", wbad, 0);
        chk("rx_stop", stops, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        addr  = 1'b1;
        d_in  = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ctrl", d_out, 32'h0000_0008);
        chk("rst_lines", {30'd0, SL0, SL1}, 32'd3);
        addr = 1'b0;
        #1;
        chk("rst_data", d_out, 32'd0);
        addr = 1'b1;

        send_frame(32'h0000_00A5, 0, 0);
        send_frame($urandom, 1, 5);
        send_frame($urandom, 2, 7);

        for (int m = 0; m < 4; m++) begin
            for (int l = 8; l <= 32; l += 2) begin
                ctrl_write(l, m);
                send_frame($urandom, 0, 0);
            end
        end
        for (int m = 4; m < 6; m++) begin
            for (int l = 8; l <= 32; l += 12) begin
                ctrl_write(l, m);
                send_frame($urandom, 0, 0);
            end
        end

        ctrl_write(3, 7);
        send_frame($urandom, 0, 0);
        ctrl_write(40, 0);
        send_frame($urandom, 0, 0);
        ctrl_write(63, 0);
        ctrl_write(0, 6);

        ctrl_write(16, 1);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = 1'b0;
        d_in  = $urandom;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        exp_len  = 8;
        exp_mode = 0;
        exp_done = 1'b0;
        chk("mid_rst_lines", {30'd0, SL0, SL1}, 32'd3);
        chk("mid_rst_ctrl", d_out, 32'h0000_0008);
        addr = 1'b0;
        #1;
        chk("mid_rst_data", d_out, 32'd0);
        addr  = 1'b1;
        rst_n = 1'b1;
        send_frame($urandom, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
